// File: rtl/neuron_stim_checker_if.sv
// Bus between the neuron stimulus/checker block and whatever surrounds it
// (neuron under test, reference model, control).
//   start        : run request, level-sampled by the checker
//   q, qRef      : neuron output and reference output fed back for comparison
//   d            : eight 8-bit operands, d[0] = D0 ... d[7] = D7
//   busy, done   : run status
//   err          : sticky first-mismatch flag
//   passCnt      : saturating count of matching compares
//   failCnt      : saturating count of mismatching compares
//   firstErrIdx  : vector index of the first mismatch
//   firstErrQ    : q captured at the first mismatch
//   firstErrRef  : qRef captured at the first mismatch
// The checker connects as master; the environment connects as slave.
interface neuron_stim_checker_if #(
  parameter int unsigned CNT_W = 16
);
  logic                  start;
  logic [7:0]            q;
  logic [7:0]            qRef;
  logic [7:0][7:0]       d;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [CNT_W-1:0]      passCnt;
  logic [CNT_W-1:0]      failCnt;
  logic [CNT_W-1:0]      firstErrIdx;
  logic [7:0]            firstErrQ;
  logic [7:0]            firstErrRef;

  modport master (
    input  start, q, qRef,
    output d, busy, done, err, passCnt, failCnt,
           firstErrIdx, firstErrQ, firstErrRef
  );

  modport slave (
    output start, q, qRef,
    input  d, busy, done, err, passCnt, failCnt,
           firstErrIdx, firstErrQ, firstErrRef
  );
endinterface

// File: rtl/neuron_stim_checker.sv
// Stimulus source and result checker for the digital neuron.
// A 64-bit Fibonacci LFSR supplies one operand vector per clock while running;
// the neuron output is compared against the reference output LAT cycles
// later, with pass/fail counting and first-error capture.
// Ports:
//   ck1_i  : sample clock, all logic on the rising edge
//   rstb_i : synchronous active-low reset
//   ifc    : master side of neuron_stim_checker_if (start, q, qRef in;
//            d, status, counters and first-error capture out)
module neuron_stim_checker #(
  parameter int unsigned N_ITER = 80,
  parameter int unsigned LAT    = 1,
  parameter logic [63:0] SEED   = 64'h0123_4567_89AB_CDEF,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  ck1_i,
  input  logic                  rstb_i,
  neuron_stim_checker_if.master ifc
);

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [63:0] SEED_EFF = (SEED == 64'h0) ? 64'h1 : SEED;

  // Internal index width is sized from the run length, not CNT_W, so a narrow
  // counter configuration still sequences the full run correctly.
  localparam int unsigned IW = $clog2(N_ITER + LAT + 1) + 1;
  localparam logic [IW-1:0] N_ITER_W   = IW'(N_ITER);
  localparam logic [IW-1:0] LAST_ISSUE = IW'(N_ITER - 1);
  localparam logic [IW-1:0] RUN_LAST   = IW'(N_ITER + LAT - 1);
  localparam logic [IW-1:0] LAT_W      = IW'(LAT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [63:0]      lfsr_q;
  logic [63:0]      lfsr_d;
  logic [IW-1:0]    issueCnt_q;
  logic [IW-1:0]    runCnt_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic [CNT_W-1:0] passCnt_q;
  logic [CNT_W-1:0] failCnt_q;
  logic [CNT_W-1:0] firstErrIdx_q;
  logic [7:0]       firstErrQ_q;
  logic [7:0]       firstErrRef_q;

  logic             issueValid;
  logic             cmpValid;
  logic [IW-1:0]    cmpIdx;

  // Next LFSR state (taps 64,63,61,60), whether a new vector is being issued
  // this cycle, and the index of the vector whose result is being compared.
  // The compare index is derived from the run cycle count: the result seen in
  // run cycle c belongs to vector c-LAT.
  always_comb begin
    lfsr_d     = {lfsr_q[62:0], lfsr_q[63] ^ lfsr_q[62] ^ lfsr_q[60] ^ lfsr_q[59]};
    issueValid = (state_q == RUN) && (issueCnt_q < N_ITER_W);
    cmpIdx     = runCnt_q - LAT_W;
  end

  // Compare-valid pipeline: with no latency the issue strobe itself marks the
  // compare; otherwise it is delayed through a LAT-deep shift register.
  generate
    if (LAT == 0) begin : gNoLat
      assign cmpValid = issueValid;
    end else begin : gLat
      logic [LAT-1:0] validPipe_q;

      always_ff @(posedge ck1_i) begin
        if (!rstb_i) begin
          validPipe_q <= '0;
        end else begin
          validPipe_q[0] <= issueValid;
          for (int i = 1; i < LAT; i++) begin
            validPipe_q[i] <= validPipe_q[i-1];
          end
        end
      end

      assign cmpValid = validPipe_q[LAT-1];
    end
  endgenerate

  // Run controller, vector generator and result checker. A start request in
  // IDLE or DONE reloads the seed and clears all results. In RUN the LFSR
  // advances once per issued vector except after the last one, so D holds the
  // final vector through drain and DONE. The run lasts N_ITER+LAT cycles so
  // the final compare lands on the edge that raises DONE.
  always_ff @(posedge ck1_i) begin
    if (!rstb_i) begin
      state_q       <= IDLE;
      lfsr_q        <= SEED_EFF;
      issueCnt_q    <= '0;
      runCnt_q      <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      passCnt_q     <= '0;
      failCnt_q     <= '0;
      firstErrIdx_q <= '0;
      firstErrQ_q   <= '0;
      firstErrRef_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (ifc.start) begin
            state_q       <= RUN;
            lfsr_q        <= SEED_EFF;
            issueCnt_q    <= '0;
            runCnt_q      <= '0;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            passCnt_q     <= '0;
            failCnt_q     <= '0;
            firstErrIdx_q <= '0;
            firstErrQ_q   <= '0;
            firstErrRef_q <= '0;
          end
        end

        RUN: begin
          if (issueValid) begin
            issueCnt_q <= issueCnt_q + IW'(1);
            if (issueCnt_q < LAST_ISSUE) begin
              lfsr_q <= lfsr_d;
            end
          end

          runCnt_q <= runCnt_q + IW'(1);

          // X/Z on q fails the equality test and falls into the mismatch arm.
          if (cmpValid) begin
            if (ifc.q == ifc.qRef) begin
              if (passCnt_q != '1) begin
                passCnt_q <= passCnt_q + CNT_W'(1);
              end
            end else begin
              if (failCnt_q != '1) begin
                failCnt_q <= failCnt_q + CNT_W'(1);
              end
              if (!err_q) begin
                err_q         <= 1'b1;
                firstErrIdx_q <= CNT_W'(cmpIdx);
                firstErrQ_q   <= ifc.q;
                firstErrRef_q <= ifc.qRef;
              end
            end
          end

          if (runCnt_q == RUN_LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ifc.d           = lfsr_q;
  assign ifc.busy        = busy_q;
  assign ifc.done        = done_q;
  assign ifc.err         = err_q;
  assign ifc.passCnt     = passCnt_q;
  assign ifc.failCnt     = failCnt_q;
  assign ifc.firstErrIdx = firstErrIdx_q;
  assign ifc.firstErrQ   = firstErrQ_q;
  assign ifc.firstErrRef = firstErrRef_q;

endmodule

// File: tb/tb_neuron_stim_checker.sv
// Testbench for neuron_stim_checker.
// Two instances: the default configuration (N_ITER=80, LAT=1, CNT_W=16) and a
// narrow one (N_ITER=20, LAT=0, CNT_W=4) used for counter saturation.
// A small neuron model feeds q/qRef back; an error-injection mode corrupts q
// for selected vectors, recognised by matching D against a software LFSR.
module tb_neuron_stim_checker;

  localparam logic [63:0] SEED = 64'h0123_4567_89AB_CDEF;

  logic clk;
  logic rstb;

  neuron_stim_checker_if #(.CNT_W(16)) ifc ();
  neuron_stim_checker_if #(.CNT_W(4))  ifc2 ();

  neuron_stim_checker #(
    .N_ITER(80), .LAT(1), .SEED(SEED), .CNT_W(16)
  ) dut (
    .ck1_i  (clk),
    .rstb_i (rstb),
    .ifc    (ifc.master)
  );

  neuron_stim_checker #(
    .N_ITER(20), .LAT(0), .SEED(SEED), .CNT_W(4)
  ) dut2 (
    .ck1_i  (clk),
    .rstb_i (rstb),
    .ifc    (ifc2.master)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;
  int errMode    = 0;

  logic [63:0] gold [80];
  logic [7:0]  refQ;
  logic [7:0]  injMask;

  // Software LFSR: shift left, new bit0 from taps 64,63,61,60.
  function automatic logic [63:0] lfsrStep(input logic [63:0] x);
    return {x[62:0], x[63] ^ x[62] ^ x[60] ^ x[59]};
  endfunction

  // Stand-in neuron: byte sum of the operand vector.
  function automatic logic [7:0] neuronModel(input logic [63:0] v);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < 8; i++) s = s + v[i*8 +: 8];
    return s;
  endfunction

  // Registered neuron/reference for the LAT=1 instance. Error modes:
  // 1 flips bit0 of vector 5; 2 inverts every result; 3 flips bit0 of
  // vector 5 and all bits of vector 10.
  always @(posedge clk) begin
    refQ <= neuronModel(ifc.d);
    if (errMode == 2)
      injMask <= 8'hFF;
    else if ((errMode == 1 || errMode == 3) && ifc.d == gold[5])
      injMask <= 8'h01;
    else if (errMode == 3 && ifc.d == gold[10])
      injMask <= 8'hFF;
    else
      injMask <= 8'h00;
  end

  assign ifc.qRef  = refQ;
  assign ifc.q     = refQ ^ injMask;
  assign ifc2.qRef = neuronModel(ifc2.d);
  assign ifc2.q    = neuronModel(ifc2.d);

  // One comparison: counts it, reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Single-cycle START pulse; returns at the negedge of RUN cycle 0.
  task automatic pulseStart();
    @(negedge clk);
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
  endtask

  // Reset, select the error mode and start a run on the main instance.
  task automatic applyStimulus(input int mode);
    @(negedge clk);
    rstb = 1'b0;
    errMode = mode;
    @(negedge clk);
    rstb = 1'b1;
    pulseStart();
  endtask

  // Bounded wait for DONE; an expired budget shows up as a failed check.
  task automatic waitDone(input int maxCycles);
    int n;
    n = 0;
    while (ifc.done !== 1'b1 && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput("doneReached", {63'h0, ifc.done}, 64'h1);
  endtask

  typedef struct {
    int          mode;
    int          expPass;
    int          expFail;
    logic        expErr;
    int          expIdx;
    logic [7:0]  expXor;
  } runVec_t;

  runVec_t runTable [4];

  initial begin
    // Expected run results for each injection mode, computed by hand.
    runTable[0] = '{mode: 0, expPass: 80, expFail: 0,  expErr: 1'b0, expIdx: 0, expXor: 8'h00};
    runTable[1] = '{mode: 1, expPass: 79, expFail: 1,  expErr: 1'b1, expIdx: 5, expXor: 8'h01};
    runTable[2] = '{mode: 3, expPass: 78, expFail: 2,  expErr: 1'b1, expIdx: 5, expXor: 8'h01};
    runTable[3] = '{mode: 2, expPass: 0,  expFail: 80, expErr: 1'b1, expIdx: 0, expXor: 8'hFF};

    gold[0] = SEED;
    for (int k = 1; k < 80; k++) gold[k] = lfsrStep(gold[k-1]);

    rstb       = 1'b0;
    ifc.start  = 1'b0;
    ifc2.start = 1'b0;
    stepCycles(2);

    // Reset state.
    checkOutput("rstBusy", {63'h0, ifc.busy}, 64'h0);
    checkOutput("rstDone", {63'h0, ifc.done}, 64'h0);
    checkOutput("rstErr",  {63'h0, ifc.err},  64'h0);
    checkOutput("rstPass", {48'h0, ifc.passCnt}, 64'h0);
    checkOutput("rstFail", {48'h0, ifc.failCnt}, 64'h0);
    checkOutput("rstD",    ifc.d, SEED);
    rstb = 1'b1;

    // T1/T2: run timing and LFSR sequence against hand and software values.
    applyStimulus(0);
    checkOutput("t1BusyC0", {63'h0, ifc.busy}, 64'h1);
    checkOutput("t2Vec0",   ifc.d, gold[0]);
    stepCycles(1);
    checkOutput("t2Vec1",   ifc.d, gold[1]);
    checkOutput("t2Vec1Hand", ifc.d, 64'h0246_8ACF_1357_9BDE);
    stepCycles(1);
    checkOutput("t2Vec2",   ifc.d, gold[2]);
    stepCycles(77);
    checkOutput("t2Vec79",  ifc.d, gold[79]);
    stepCycles(1);
    checkOutput("t1BusyC80", {63'h0, ifc.busy}, 64'h1);
    checkOutput("t1DoneC80", {63'h0, ifc.done}, 64'h0);
    checkOutput("t1DrainD",  ifc.d, gold[79]);
    checkOutput("t1PassC80", {48'h0, ifc.passCnt}, 64'd79);
    stepCycles(1);
    checkOutput("t1DoneC81", {63'h0, ifc.done}, 64'h1);
    checkOutput("t1BusyC81", {63'h0, ifc.busy}, 64'h0);
    checkOutput("t1Pass",    {48'h0, ifc.passCnt}, 64'd80);
    checkOutput("t1Fail",    {48'h0, ifc.failCnt}, 64'd0);
    stepCycles(3);
    checkOutput("t1DoneHeld", {63'h0, ifc.done}, 64'h1);
    checkOutput("t1DoneD",    ifc.d, gold[79]);

    // T1/T3/T4: table of whole runs under different injection patterns.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(runTable[i].mode);
      waitDone(200);
      checkOutput($sformatf("row%0d pass", i), {48'h0, ifc.passCnt}, 64'(runTable[i].expPass));
      checkOutput($sformatf("row%0d fail", i), {48'h0, ifc.failCnt}, 64'(runTable[i].expFail));
      checkOutput($sformatf("row%0d err", i),  {63'h0, ifc.err}, {63'h0, runTable[i].expErr});
      checkOutput($sformatf("row%0d idx", i),  {48'h0, ifc.firstErrIdx}, 64'(runTable[i].expIdx));
      checkOutput($sformatf("row%0d xor", i),  {56'h0, ifc.firstErrQ ^ ifc.firstErrRef},
                  {56'h0, runTable[i].expXor});
    end

    // T4: restart from DONE clears results and reloads the seed.
    errMode = 0;
    pulseStart();
    checkOutput("t4Busy", {63'h0, ifc.busy}, 64'h1);
    checkOutput("t4Done", {63'h0, ifc.done}, 64'h0);
    checkOutput("t4Pass", {48'h0, ifc.passCnt}, 64'h0);
    checkOutput("t4Fail", {48'h0, ifc.failCnt}, 64'h0);
    checkOutput("t4Err",  {63'h0, ifc.err}, 64'h0);
    checkOutput("t4Idx",  {48'h0, ifc.firstErrIdx}, 64'h0);
    checkOutput("t4D",    ifc.d, SEED);
    waitDone(200);
    checkOutput("t4RerunPass", {48'h0, ifc.passCnt}, 64'd80);

    // T5: reset in RUN cycle 30, then a clean rerun.
    applyStimulus(0);
    stepCycles(30);
    checkOutput("t5MidPass", {48'h0, ifc.passCnt}, 64'd29);
    checkOutput("t5MidD",    ifc.d, gold[30]);
    rstb = 1'b0;
    stepCycles(1);
    checkOutput("t5Busy", {63'h0, ifc.busy}, 64'h0);
    checkOutput("t5Done", {63'h0, ifc.done}, 64'h0);
    checkOutput("t5D",    ifc.d, SEED);
    checkOutput("t5Pass", {48'h0, ifc.passCnt}, 64'h0);
    checkOutput("t5Fail", {48'h0, ifc.failCnt}, 64'h0);
    rstb = 1'b1;
    stepCycles(2);
    checkOutput("t5IdleHold", {63'h0, ifc.busy}, 64'h0);
    pulseStart();
    waitDone(200);
    checkOutput("t5RerunPass", {48'h0, ifc.passCnt}, 64'd80);
    checkOutput("t5RerunFail", {48'h0, ifc.failCnt}, 64'd0);
    checkOutput("t5RerunErr",  {63'h0, ifc.err}, 64'h0);

    // T6: narrow counters, zero latency, saturation at 15.
    @(negedge clk);
    ifc2.start = 1'b1;
    @(negedge clk);
    ifc2.start = 1'b0;
    checkOutput("t6BusyC0", {63'h0, ifc2.busy}, 64'h1);
    checkOutput("t6PassC0", {60'h0, ifc2.passCnt}, 64'd0);
    stepCycles(10);
    checkOutput("t6PassC10", {60'h0, ifc2.passCnt}, 64'd10);
    stepCycles(9);
    checkOutput("t6DoneC19", {63'h0, ifc2.done}, 64'h0);
    checkOutput("t6PassC19", {60'h0, ifc2.passCnt}, 64'd15);
    stepCycles(1);
    checkOutput("t6DoneC20", {63'h0, ifc2.done}, 64'h1);
    checkOutput("t6BusyC20", {63'h0, ifc2.busy}, 64'h0);
    checkOutput("t6Pass",    {60'h0, ifc2.passCnt}, 64'd15);
    checkOutput("t6Fail",    {60'h0, ifc2.failCnt}, 64'd0);
    checkOutput("t6Err",     {63'h0, ifc2.err}, 64'h0);
    checkOutput("t6D",       ifc2.d, gold[19]);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
